mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the accelerator's single HCI/TCDM memory port between N_REQ requesters:
//  X-metadata fetch, Y-block load from the Y address stream, and Z writeback.
//  Round-robin arbitration with a registered request slot.
//  Tracks outstanding reads in an ID FIFO so each read response returns to its issuer.
//  Sits between the data schedulers/streamers and the HCI core port.
// PARAMETERS
//  N_REQ           3    number of requesters (index 0 = META, 1 = Y, 2 = Z)
//  ADDR_WIDTH      32   byte address width
//  DATA_WIDTH      128  memory word width
//  MAX_OUTSTANDING 4    reads in flight before issue stalls (power of 2, >= 2)
// PORTS
//  clk_i        in   1                     clock
//  rst_ni       in   1                     asynchronous, active-low reset
//  clear_i      in   1                     synchronous clear of all state
//  enable_i     in   1                     arbitration enabled
//  req_valid_i  in   N_REQ                 per-requester request valid
//  req_ready_o  out  N_REQ                 per-requester request accepted
//  req_addr_i   in   N_REQ*ADDR_WIDTH      request byte address
//  req_we_i     in   N_REQ                 1 = write, 0 = read
//  req_wdata_i  in   N_REQ*DATA_WIDTH      write data
//  req_be_i     in   N_REQ*DATA_WIDTH/8    byte enables
//  mem_req_o    out  1                     HCI request
//  mem_gnt_i    in   1                     HCI grant
//  mem_add_o    out  ADDR_WIDTH            HCI address
//  mem_wen_o    out  1                     HCI write-enable, active-low (0 = write)
//  mem_data_o   out  DATA_WIDTH            HCI write data
//  mem_be_o     out  DATA_WIDTH/8          HCI byte enables
//  mem_r_valid_i in  1                     read response valid (reads only)
//  mem_r_data_i in   DATA_WIDTH            read response data
//  rsp_valid_o  out  N_REQ                 one-hot response strobe
//  rsp_data_o   out  DATA_WIDTH            response data, shared by all requesters
//  busy_o       out  1                     slot occupied or reads outstanding
//  err_o        out  1                     sticky: r_valid arrived with empty ID FIFO
// BEHAVIOUR
//  - Reset / clear values:
//    - all outputs 0, except mem_wen_o = 1
//    - RR pointer = 0; slot empty; ID FIFO empty; err_o = 0
//  - Arbitration:
//    - Winner = first valid requester at or after the RR pointer.
//    - Requesters are eligible only if enable_i = 1.
//    - A read is eligible only if the ID FIFO count plus reads in the slot < MAX_OUTSTANDING.
//  - Accept:
//    - req_ready_o[w] = 1 iff the slot is empty, or the slot is granted this cycle (mem_gnt_i && mem_req_o).
//    - At most one ready bit is high per cycle.
//    - On acceptance: capture addr/we/wdata/be/id into the slot; RR pointer <- w+1, mod N_REQ.
//  - Issue:
//    - mem_req_o = slot full; asserted the cycle after acceptance (1-cycle latency).
//    - mem_add/wen/data/be stay stable until mem_gnt_i; the slot never changes while ungranted.
//    - Back-to-back: grant and accept in the same cycle refill the slot, giving one request per cycle.
//  - Tracking:
//    - A granted read pushes the slot id into the ID FIFO.
//    - Writes push nothing and produce no rsp_valid_o.
//  - Response:
//    - mem_r_valid_i pops the ID FIFO in the same cycle (combinational).
//    - rsp_valid_o[id] = 1 and rsp_data_o = mem_r_data_i, with zero latency.
//    - Responses cannot be back-pressured.
//  - Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
//  - mem_r_valid_i with an empty FIFO: no rsp_valid_o, err_o <- 1, held until clear/reset.
//  - clear_i or reset mid-operation: slot and outstanding IDs are discarded.
//    - Later orphan r_valids set err_o; the controller must drain before clearing.
//  - enable_i = 0: no new accepts; a full slot still issues until granted.
//  - busy_o = slot full || FIFO not empty.
// CONFIGURATION
//  - MEM_ARB_FIXED_PRIO_EN defined:
//    - Fixed priority, lowest index wins (META > Y > Z); the RR pointer is removed.
//    - Starvation of higher indices is accepted.
//  - MEM_ARB_FIXED_PRIO_EN undefined: round-robin as above (default).
// STRUCTURE
//  - accelerator_package:
//    - mem_req_t struct {addr, we, wdata, be, id}
//    - localparams REQ_META = 0, REQ_Y = 1, REQ_Z = 2; MEM_ARB_N_REQ = 3
//  - Sub-module mem_arb_id_fifo:
//    - width $clog2(N_REQ), depth MAX_OUTSTANDING
//    - push/pop/full/empty/count; simultaneous push and pop when full is legal
//  - Top level: arbiter comb, slot register, response demux, err flag.
// TESTING
//  1. Req1 reads 0x100; gnt after 2 stall cycles; r_valid 1 cycle later with data 0xA5..
//     -> mem_add_o held at 0x100 for 3 cycles; rsp_valid_o = 3'b010; rsp_data_o = 0xA5..
//  2. All 3 valid for 9 cycles, gnt tied 1, r_valid 2 cycles after each grant
//     -> grant order 0,1,2,0,1,2,...; one mem_req_o per cycle; responses routed in order.
//  3. Req0 issues 5 reads with gnt = 1 and no r_valid
//     -> reads 1-4 accepted; req_ready_o[0] = 0 for read 5 until the first r_valid.
//  4. Req2 writes 0x200, be = 16'h00FF -> mem_wen_o = 0, mem_be_o = 16'h00FF; FIFO count unchanged; no rsp_valid_o.
//  5. r_valid pulse with FIFO empty -> err_o = 1, held through later traffic; cleared by clear_i.
//  6. MEM_ARB_FIXED_PRIO_EN, req0 and req1 valid for 6 cycles -> req1 never ready.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and constants for the HCI memory port arbiter.
package mem_port_arbiter_pkg;
    localparam int MEM_ARB_N_REQ = 3;
    localparam int REQ_META = 0;
    localparam int REQ_Y = 1;
    localparam int REQ_Z = 2;
    localparam int MEM_ARB_ADDR_WIDTH = 32;
    localparam int MEM_ARB_DATA_WIDTH = 128;
    localparam int MEM_ARB_ID_WIDTH = $clog2(MEM_ARB_N_REQ);

    typedef struct packed {
        logic [MEM_ARB_ADDR_WIDTH-1:0]   addr;
        logic                            we;
        logic [MEM_ARB_DATA_WIDTH-1:0]   wdata;
        logic [MEM_ARB_DATA_WIDTH/8-1:0] be;
        logic [MEM_ARB_ID_WIDTH-1:0]     id;
    } mem_req_t;

    function automatic int rr_next(input int w, input int n);
        return (w + 1) % n;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, HCI and response signals of mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic [N_REQ-1:0]              req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
    logic [N_REQ*ADDR_WIDTH-1:0]   req_addr_i;
    logic [N_REQ*DATA_WIDTH-1:0]   req_wdata_i;
    logic [N_REQ*DATA_WIDTH/8-1:0] req_be_i;
    logic                          mem_req_o, mem_gnt_i, mem_wen_o, mem_r_valid_i;
    logic [ADDR_WIDTH-1:0]         mem_add_o;
    logic [DATA_WIDTH-1:0]         mem_data_o, mem_r_data_i, rsp_data_o;
    logic [DATA_WIDTH/8-1:0]       mem_be_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i,
        input  mem_gnt_i, mem_r_valid_i, mem_r_data_i,
        output req_ready_o, mem_req_o, mem_add_o, mem_wen_o, mem_data_o, mem_be_o,
        output rsp_valid_o, rsp_data_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i,
        output mem_gnt_i, mem_r_valid_i, mem_r_data_i,
        input  req_ready_o, mem_req_o, mem_add_o, mem_wen_o, mem_data_o, mem_be_o,
        input  rsp_valid_o, rsp_data_o
    );
endinterface

// File: rtl/mem_arb_id_fifo.sv
// mem_arb_id_fifo: FIFO of requester ids for reads in flight; push and pop together when full is legal.
module mem_arb_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic             do_push, do_pop;

    assign full_o  = count_o == CNT_W'(DEPTH);
    assign empty_o = count_o == '0;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_o <= '0;
        end else if (clear_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            count_o <= count_o + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i)
        if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one HCI port between N_REQ requesters, routing read responses by id.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_REQ = MEM_ARB_N_REQ,
    parameter int ADDR_WIDTH = MEM_ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_ARB_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              enable_i,
    mem_port_arbiter_if.slave bus,
    output logic              busy_o,
    output logic              err_o
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int BE_W = DATA_WIDTH / 8;

    mem_req_t         slot_q, req_sel;
    logic             slot_full_q, fire, accept, found, read_ok, rsp_hit;
    logic             fifo_empty, fifo_full, fifo_push;
    logic [ID_W-1:0]  win, rsp_id;
    logic [CNT_W-1:0] fifo_count;
    logic [N_REQ-1:0] elig;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] ptr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else if (clear_i) ptr_q <= '0;
        else if (accept) ptr_q <= ID_W'(rr_next(int'(win), N_REQ));
    end
`endif

    // A read still sitting in the slot already reserves a FIFO entry.
    assign read_ok   = int'(fifo_count) + int'(slot_full_q && !slot_q.we) < MAX_OUTSTANDING;
    assign fire      = slot_full_q && bus.mem_gnt_i;
    assign accept    = (!slot_full_q || fire) && found;
    assign fifo_push = fire && !slot_q.we;

    always_comb begin
        int idx;
        elig  = enable_i ? bus.req_valid_i & (bus.req_we_i | {N_REQ{read_ok}}) : '0;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(ptr_q) + k) % N_REQ;
`endif
            if (elig[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_sel.addr  = bus.req_addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        req_sel.we    = bus.req_we_i[win];
        req_sel.wdata = bus.req_wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        req_sel.be    = bus.req_be_i[int'(win)*BE_W +: BE_W];
        req_sel.id    = win;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q      <= '0;
            slot_full_q <= 1'b0;
            err_o       <= 1'b0;
        end else if (clear_i) begin
            slot_q      <= '0;
            slot_full_q <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            if (accept) begin
                slot_q      <= req_sel;
                slot_full_q <= 1'b1;
            end else if (fire) begin
                slot_full_q <= 1'b0;
            end
            if (bus.mem_r_valid_i && fifo_empty) err_o <= 1'b1;
        end
    end

    mem_arb_id_fifo #(
        .WIDTH(ID_W),
        .DEPTH(MAX_OUTSTANDING)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (fifo_push),
        .data_i  (slot_q.id),
        .pop_i   (bus.mem_r_valid_i),
        .data_o  (rsp_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The outstanding-read budget makes a push into a full FIFO without a pop unreachable.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(fifo_full && fifo_push && !bus.mem_r_valid_i));

    assign bus.req_ready_o = accept ? N_REQ'(1) << win : '0;
    assign bus.mem_req_o   = slot_full_q;
    assign bus.mem_add_o   = slot_q.addr;
    assign bus.mem_wen_o   = ~slot_q.we;
    assign bus.mem_data_o  = slot_q.wdata;
    assign bus.mem_be_o    = slot_q.be;
    assign rsp_hit         = bus.mem_r_valid_i && !fifo_empty;
    assign bus.rsp_valid_o = rsp_hit ? N_REQ'(1) << rsp_id : '0;
    assign bus.rsp_data_o  = rsp_hit ? bus.mem_r_data_i : '0;
    assign busy_o          = slot_full_q || !fifo_empty;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_mem_port_arbiter;
    localparam int N = 3;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int BW = 16;
    localparam int MAXO = 4;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic clear_i = 1'b0;
    logic enable_i = 1'b0;
    logic busy_o, err_o;
    int total = 0;
    int bad = 0;

    mem_port_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
        .bus(bus), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        bus.req_valid_i = '0;
        bus.req_we_i = '0;
        bus.req_addr_i = '0;
        bus.req_wdata_i = '0;
        bus.req_be_i = '0;
        bus.mem_gnt_i = 1'b0;
        bus.mem_r_valid_i = 1'b0;
        bus.mem_r_data_i = '0;
        clear_i = 1'b0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
        bus.req_valid_i[i] = 1'b1;
        bus.req_we_i[i] = we;
        bus.req_addr_i[i*AW +: AW] = a;
        bus.req_wdata_i[i*DW +: DW] = d;
        bus.req_be_i[i*BW +: BW] = be;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        total++; if (bus.mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0h exp=0", bus.mem_req_o); end
        total++; if (bus.mem_wen_o !== 1'b1) begin bad++; $display("FAIL reset_mem_wen got=%0h exp=1", bus.mem_wen_o); end
        total++; if (bus.mem_add_o !== '0) begin bad++; $display("FAIL reset_mem_add got=%0h exp=0", bus.mem_add_o); end
        total++; if (bus.mem_be_o !== '0) begin bad++; $display("FAIL reset_mem_be got=%0h exp=0", bus.mem_be_o); end
        total++; if (bus.rsp_valid_o !== '0) begin bad++; $display("FAIL reset_rsp_valid got=%0h exp=0", bus.rsp_valid_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h exp=0", err_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        logic [DW-1:0] d = {16{8'hA5}};
        set_req(1, 1'b0, 32'h100, '0, '1);
        @(negedge clk_i);
        total++; if (bus.req_ready_o !== 3'b010) begin bad++; $display("FAIL rd_ready got=%0h exp=2", bus.req_ready_o); end
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            bus.mem_gnt_i = (c == 2);
            @(negedge clk_i);
            total++; if (bus.mem_req_o !== 1'b1) begin bad++; $display("FAIL rd_req c=%0d got=%0h exp=1", c, bus.mem_req_o); end
            total++; if (bus.mem_add_o !== 32'h100) begin bad++; $display("FAIL rd_add c=%0d got=%0h exp=100", c, bus.mem_add_o); end
            total++; if (bus.mem_wen_o !== 1'b1) begin bad++; $display("FAIL rd_wen c=%0d got=%0h exp=1", c, bus.mem_wen_o); end
            tick();
        end
        bus.mem_gnt_i = 1'b0;
        bus.mem_r_valid_i = 1'b1;
        bus.mem_r_data_i = d;
        @(negedge clk_i);
        total++; if (bus.rsp_valid_o !== 3'b010) begin bad++; $display("FAIL rd_rsp_valid got=%0h exp=2", bus.rsp_valid_o); end
        total++; if (bus.rsp_data_o !== d) begin bad++; $display("FAIL rd_rsp_data got=%0h exp=%0h", bus.rsp_data_o, d); end
        tick();
        idle();
        @(negedge clk_i);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rd_busy_after got=%0h exp=0", busy_o); end
        total++; if (bus.mem_req_o !== 1'b0) begin bad++; $display("FAIL rd_req_after got=%0h exp=0", bus.mem_req_o); end
        tick();
    endtask

    task automatic test_write();
        logic [DW-1:0] d = {$urandom, $urandom, $urandom, $urandom};
        set_req(2, 1'b1, 32'h200, d, 16'h00FF);
        @(negedge clk_i);
        total++; if (bus.req_ready_o !== 3'b100) begin bad++; $display("FAIL wr_ready got=%0h exp=4", bus.req_ready_o); end
        tick();
        idle();
        bus.mem_gnt_i = 1'b1;
        @(negedge clk_i);
        total++; if (bus.mem_req_o !== 1'b1) begin bad++; $display("FAIL wr_req got=%0h exp=1", bus.mem_req_o); end
        total++; if (bus.mem_wen_o !== 1'b0) begin bad++; $display("FAIL wr_wen got=%0h exp=0", bus.mem_wen_o); end
        total++; if (bus.mem_be_o !== 16'h00FF) begin bad++; $display("FAIL wr_be got=%0h exp=ff", bus.mem_be_o); end
        total++; if (bus.mem_add_o !== 32'h200) begin bad++; $display("FAIL wr_add got=%0h exp=200", bus.mem_add_o); end
        total++; if (bus.mem_data_o !== d) begin bad++; $display("FAIL wr_data got=%0h exp=%0h", bus.mem_data_o, d); end
        tick();
        idle();
        @(negedge clk_i);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL wr_busy got=%0h exp=0", busy_o); end
        total++; if (bus.rsp_valid_o !== '0) begin bad++; $display("FAIL wr_rsp got=%0h exp=0", bus.rsp_valid_o); end
        tick();
    endtask

    task automatic test_outstanding();
        logic [DW-1:0] d;
        logic [N-1:0] exp;
        set_req(0, 1'b0, 32'h300, '0, '1);
        bus.mem_gnt_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            exp = (c < MAXO) ? 3'b001 : 3'b000;
            @(negedge clk_i);
            total++; if (bus.req_ready_o !== exp) begin bad++; $display("FAIL out_ready c=%0d got=%0h exp=%0h", c, bus.req_ready_o, exp); end
            tick();
        end
        d = {$urandom, $urandom, $urandom, $urandom};
        bus.mem_r_valid_i = 1'b1;
        bus.mem_r_data_i = d;
        @(negedge clk_i);
        total++; if (bus.req_ready_o !== 3'b000) begin bad++; $display("FAIL out_ready_pop got=%0h exp=0", bus.req_ready_o); end
        total++; if (bus.rsp_valid_o !== 3'b001) begin bad++; $display("FAIL out_rsp_first got=%0h exp=1", bus.rsp_valid_o); end
        total++; if (bus.rsp_data_o !== d) begin bad++; $display("FAIL out_rsp_data got=%0h exp=%0h", bus.rsp_data_o, d); end
        tick();
        bus.mem_r_valid_i = 1'b0;
        @(negedge clk_i);
        total++; if (bus.req_ready_o !== 3'b001) begin bad++; $display("FAIL out_ready_after got=%0h exp=1", bus.req_ready_o); end
        tick();
        bus.req_valid_i = '0;
        for (int k = 0; k < MAXO; k++) begin
            bus.mem_r_valid_i = 1'b1;
            bus.mem_r_data_i = DW'(k);
            @(negedge clk_i);
            total++; if (bus.rsp_valid_o !== 3'b001) begin bad++; $display("FAIL out_drain k=%0d got=%0h exp=1", k, bus.rsp_valid_o); end
            tick();
        end
        idle();
        @(negedge clk_i);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL out_busy got=%0h exp=0", busy_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL out_err got=%0h exp=0", err_o); end
        tick();
    endtask

`ifndef MEM_ARB_FIXED_PRIO_EN
    task automatic test_round_robin();
        logic [N-1:0] exp_ready;
        logic exp_req;
        idle();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h1000 + 32'(i) * 32'h40, '0, '1);
        bus.mem_gnt_i = 1'b1;
        for (int t = 0; t < 13; t++) begin
            bus.req_valid_i = (t < 9) ? 3'b111 : 3'b000;
            bus.mem_r_valid_i = (t >= 3 && t < 12);
            bus.mem_r_data_i = {4{32'(t)}};
            exp_ready = (t < 9) ? 3'(1) << (t % N) : 3'b000;
            exp_req = (t >= 1 && t <= 9);
            @(negedge clk_i);
            total++; if (bus.req_ready_o !== exp_ready) begin bad++; $display("FAIL rr_ready t=%0d got=%0h exp=%0h", t, bus.req_ready_o, exp_ready); end
            total++; if (bus.mem_req_o !== exp_req) begin bad++; $display("FAIL rr_req t=%0d got=%0h exp=%0h", t, bus.mem_req_o, exp_req); end
            if (exp_req) begin
                total++; if (bus.mem_add_o !== 32'h1000 + 32'((t - 1) % N) * 32'h40) begin bad++; $display("FAIL rr_add t=%0d got=%0h", t, bus.mem_add_o); end
            end
            if (bus.mem_r_valid_i) begin
                total++; if (bus.rsp_valid_o !== 3'(1) << ((t - 3) % N)) begin bad++; $display("FAIL rr_rsp t=%0d got=%0h exp=%0h", t, bus.rsp_valid_o, 3'(1) << ((t - 3) % N)); end
                total++; if (bus.rsp_data_o !== {4{32'(t)}}) begin bad++; $display("FAIL rr_rsp_data t=%0d got=%0h", t, bus.rsp_data_o); end
            end
            tick();
        end
        idle();
        @(negedge clk_i);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rr_busy got=%0h exp=0", busy_o); end
        tick();
    endtask
`else
    task automatic test_fixed();
        idle();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        set_req(0, 1'b1, 32'h10, '0, '1);
        set_req(1, 1'b1, 32'h20, '0, '1);
        bus.mem_gnt_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            total++; if (bus.req_ready_o !== 3'b001) begin bad++; $display("FAIL fixed_ready c=%0d got=%0h exp=1", c, bus.req_ready_o); end
            tick();
        end
        idle();
        tick();
    endtask
`endif

    task automatic test_err();
        idle();
        bus.mem_r_valid_i = 1'b1;
        bus.mem_r_data_i = '1;
        @(negedge clk_i);
        total++; if (bus.rsp_valid_o !== '0) begin bad++; $display("FAIL err_rsp got=%0h exp=0", bus.rsp_valid_o); end
        tick();
        bus.mem_r_valid_i = 1'b0;
        @(negedge clk_i);
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_set got=%0h exp=1", err_o); end
        tick();
        set_req(0, 1'b1, 32'h40, '1, '1);
        bus.mem_gnt_i = 1'b1;
        @(negedge clk_i);
        total++; if (bus.req_ready_o !== 3'b001) begin bad++; $display("FAIL err_wr_ready got=%0h exp=1", bus.req_ready_o); end
        tick();
        bus.req_valid_i = '0;
        @(negedge clk_i);
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_held got=%0h exp=1", err_o); end
        tick();
        set_req(1, 1'b0, 32'h80, '0, '1);
        tick();
        bus.req_valid_i = '0;
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        @(negedge clk_i);
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_clear got=%0h exp=0", err_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL err_clear_busy got=%0h exp=0", busy_o); end
        tick();
        bus.mem_r_valid_i = 1'b1;
        @(negedge clk_i);
        total++; if (bus.rsp_valid_o !== '0) begin bad++; $display("FAIL err_orphan_rsp got=%0h exp=0", bus.rsp_valid_o); end
        tick();
        bus.mem_r_valid_i = 1'b0;
        @(negedge clk_i);
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_orphan got=%0h exp=1", err_o); end
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        @(negedge clk_i);
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_final_clear got=%0h exp=0", err_o); end
        tick();
    endtask

    task automatic test_random();
        int ptr = 0;
        bit sf = 0;
        bit s_we = 0;
        int s_id = 0;
        logic [AW-1:0] s_addr = '0;
        logic [DW-1:0] s_data = '0;
        logic [BW-1:0] s_be = '0;
        int q[$];
        idle();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int c = 0; c < 300; c++) begin
            int w;
            int i;
            bit fire;
            bit budget;
            bit take;
            logic [N-1:0] exp_ready;
            logic [N-1:0] exp_rsp;
            logic [DW-1:0] rdata;
            enable_i = ($urandom_range(7) != 0);
            for (int r = 0; r < N; r++) begin
                bus.req_valid_i[r] = 1'($urandom_range(1));
                bus.req_we_i[r] = ($urandom_range(3) == 0);
                bus.req_addr_i[r*AW +: AW] = $urandom;
                bus.req_wdata_i[r*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
                bus.req_be_i[r*BW +: BW] = 16'($urandom);
            end
            bus.mem_gnt_i = 1'($urandom_range(1));
            bus.mem_r_valid_i = (q.size() > 0) && ($urandom_range(2) != 0);
            rdata = {$urandom, $urandom, $urandom, $urandom};
            bus.mem_r_data_i = rdata;
            budget = (q.size() + ((sf && !s_we) ? 1 : 0)) < MAXO;
            fire = sf && bus.mem_gnt_i;
            w = -1;
            for (int k = 0; k < N; k++) begin
                i = (ptr + k) % N;
                if (w < 0 && enable_i && bus.req_valid_i[i] && (bus.req_we_i[i] || budget)) w = i;
            end
            take = (!sf || fire) && w >= 0;
            exp_ready = take ? 3'(1) << w : 3'b000;
            exp_rsp = bus.mem_r_valid_i ? 3'(1) << q[0] : 3'b000;
            @(negedge clk_i);
            total++; if (bus.req_ready_o !== exp_ready) begin bad++; $display("FAIL rnd_ready c=%0d got=%0h exp=%0h", c, bus.req_ready_o, exp_ready); end
            total++; if (bus.mem_req_o !== sf) begin bad++; $display("FAIL rnd_req c=%0d got=%0h exp=%0h", c, bus.mem_req_o, sf); end
            if (sf) begin
                total++; if (bus.mem_add_o !== s_addr) begin bad++; $display("FAIL rnd_add c=%0d got=%0h exp=%0h", c, bus.mem_add_o, s_addr); end
                total++; if (bus.mem_wen_o !== !s_we) begin bad++; $display("FAIL rnd_wen c=%0d got=%0h exp=%0h", c, bus.mem_wen_o, !s_we); end
                total++; if (bus.mem_data_o !== s_data) begin bad++; $display("FAIL rnd_data c=%0d got=%0h exp=%0h", c, bus.mem_data_o, s_data); end
                total++; if (bus.mem_be_o !== s_be) begin bad++; $display("FAIL rnd_be c=%0d got=%0h exp=%0h", c, bus.mem_be_o, s_be); end
            end
            total++; if (bus.rsp_valid_o !== exp_rsp) begin bad++; $display("FAIL rnd_rsp c=%0d got=%0h exp=%0h", c, bus.rsp_valid_o, exp_rsp); end
            if (bus.mem_r_valid_i) begin
                total++; if (bus.rsp_data_o !== rdata) begin bad++; $display("FAIL rnd_rsp_data c=%0d got=%0h exp=%0h", c, bus.rsp_data_o, rdata); end
            end
            total++; if (busy_o !== (sf || q.size() > 0)) begin bad++; $display("FAIL rnd_busy c=%0d got=%0h", c, busy_o); end
            total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rnd_err c=%0d got=%0h exp=0", c, err_o); end
            if (bus.mem_r_valid_i) void'(q.pop_front());
            if (fire && !s_we) q.push_back(s_id);
            if (take) begin
                sf = 1;
                s_addr = bus.req_addr_i[w*AW +: AW];
                s_we = bus.req_we_i[w];
                s_data = bus.req_wdata_i[w*DW +: DW];
                s_be = bus.req_be_i[w*BW +: BW];
                s_id = w;
`ifndef MEM_ARB_FIXED_PRIO_EN
                ptr = (w + 1) % N;
`endif
            end else if (fire) begin
                sf = 0;
            end
            tick();
        end
        idle();
        enable_i = 1'b1;
    endtask

    initial begin
        idle();
        enable_i = 1'b1;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        test_single_read();
        test_write();
        test_outstanding();
`ifndef MEM_ARB_FIXED_PRIO_EN
        test_round_robin();
`else
        test_fixed();
`endif
        test_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
